// File: rtl/wbmemtest_pkg.sv
// Shared definitions for the Wishbone memory self-test initiator.
//   LFSR_TAPS  : feedback taps of the 32-bit pattern generator
//   state_t    : pass sequencer states (IDLE, WRITE, GAP, READ, DONE)
//   lfsr_step  : one step of the pattern generator
package wbmemtest_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_GAP   = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/wbmemtest_lfsr.sv
// 32-bit pattern generator register.
//   clk   : clock
//   reset : synchronous active-high reset, clears the register
//   load  : load seed (has priority over step)
//   seed  : value loaded on load
//   step  : advance one LFSR step
//   value : current pattern word
module wbmemtest_lfsr
  import wbmemtest_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= seed;
    else if (step)
      value <= lfsr_step(value);
  end

endmodule

// File: rtl/wbmemtest.sv
// Pipelined Wishbone memory self-test initiator. Writes an LFSR pattern to
// words 0..i_last, then reads them back and compares in order.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_start             : start pulse (honoured in IDLE only)
//   i_seed, i_last      : pattern seed (0 -> 1) and last word, sampled on start
//   o_busy, o_done      : pass in progress / one-cycle end-of-pass pulse
//   o_fail, o_fail_addr, o_fail_data : sticky first-failure report
//   o_wb_*              : Wishbone pipelined master request side
//   i_wb_*              : Wishbone slave response side
module wbmemtest
  import wbmemtest_pkg::*;
#(
  parameter int unsigned AW    = 15,
  parameter int unsigned LGOUT = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [31:0]   i_seed,
  input  logic [AW-1:0] i_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_fail,
  output logic [AW-1:0] o_fail_addr,
  output logic [31:0]   o_fail_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  state_t           state;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    last;
  logic [AW-1:0]    ack_idx;
  logic [31:0]      seed;
  logic             more;
  logic [LGOUT-1:0] outstanding;

  logic [31:0]      issue_val;
  logic [31:0]      check_val;
  logic [31:0]      load_seed;
  logic             phase;
  logic             accept;
  logic             ack_ok;
  logic             err_ok;
  logic             bad_read;
  logic             abort;
  logic             start_ok;
  logic             reload;
  logic [LGOUT-1:0] cnt_nxt;
  logic             more_nxt;

  assign phase     = (state == S_WRITE) || (state == S_READ);
  assign o_wb_cyc  = phase;
  // Throttle at 2^LGOUT-1 so the counter can never wrap.
  assign o_wb_stb  = phase && more && (outstanding != '1);
  assign o_wb_we   = (state == S_WRITE);
  assign o_wb_addr = addr;
  assign o_wb_data = issue_val;
  assign o_wb_sel  = 4'hf;
  assign o_busy    = phase || (state == S_GAP);
  assign o_done    = (state == S_DONE);

  assign accept    = o_wb_stb && !i_wb_stall;
  assign ack_ok    = phase && i_wb_ack && (outstanding != '0);
  assign err_ok    = phase && i_wb_err;
  assign bad_read  = (state == S_READ) && ack_ok && (i_wb_data != check_val);
  assign abort     = err_ok || bad_read;
  assign start_ok  = (state == S_IDLE) && i_start;
  assign reload    = start_ok || (state == S_GAP);
  assign load_seed = start_ok ? ((i_seed == '0) ? 32'h1 : i_seed) : seed;

  always_comb begin
    cnt_nxt = outstanding;
    if (accept && !ack_ok)
      cnt_nxt = outstanding + LGOUT'(1);
    else if (!accept && ack_ok)
      cnt_nxt = outstanding - LGOUT'(1);
    // A separate "requests remain" flag lets the address stop at i_last
    // even when i_last is the top of the address space.
    more_nxt = more && !(accept && (addr == last));
  end

  wbmemtest_lfsr u_issue (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (reload),
    .seed  (load_seed),
    .step  (accept && (state == S_WRITE)),
    .value (issue_val)
  );

  wbmemtest_lfsr u_check (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (reload),
    .seed  (load_seed),
    .step  (ack_ok && (state == S_READ)),
    .value (check_val)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      last        <= '0;
      ack_idx     <= '0;
      seed        <= '0;
      more        <= 1'b0;
      outstanding <= '0;
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state       <= S_WRITE;
            seed        <= load_seed;
            last        <= i_last;
            addr        <= '0;
            ack_idx     <= '0;
            more        <= 1'b1;
            outstanding <= '0;
            o_fail      <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
          end
        end
        S_WRITE, S_READ: begin
          if (accept && (addr != last))
            addr <= addr + AW'(1);
          more        <= more_nxt;
          outstanding <= cnt_nxt;
          if (ack_ok || err_ok)
            ack_idx <= ack_idx + AW'(1);
          if (abort) begin
            state <= S_DONE;
            if (!o_fail) begin
              o_fail      <= 1'b1;
              o_fail_addr <= ack_idx;
              o_fail_data <= err_ok ? '0 : i_wb_data;
            end
          end else if (!more_nxt && (cnt_nxt == '0)) begin
            state <= (state == S_WRITE) ? S_GAP : S_DONE;
          end
        end
        S_GAP: begin
          state       <= S_READ;
          addr        <= '0;
          ack_idx     <= '0;
          more        <= 1'b1;
          outstanding <= '0;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbmemtest.sv
// Self-checking bench for wbmemtest: a queued Wishbone RAM slave with
// configurable stall, latency, read corruption and write error, plus a
// reference LFSR sequence computed directly from the pattern rule.
module tb_wbmemtest;
  localparam int unsigned AW    = 6;
  localparam int unsigned LGOUT = 2;
  localparam int          NW    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [31:0]   i_seed = '0;
  logic [AW-1:0] i_last = '0;
  logic          o_busy, o_done, o_fail;
  logic [AW-1:0] o_fail_addr;
  logic [31:0]   o_fail_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;
  logic [31:0]   i_wb_data = '0;

  always #5 clk = ~clk;

  wbmemtest #(.AW(AW), .LGOUT(LGOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_seed(i_seed), .i_last(i_last),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_fail_addr(o_fail_addr), .o_fail_data(o_fail_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  function automatic logic [31:0] lfsr_at(input logic [31:0] s, input int k);
    logic [31:0] v;
    v = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < k; i++)
      v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mem [NW];
  int          now = 0;
  int          stall_alt = 0;
  int          ack_lat = 1;
  int          corrupt_at = -1;
  int          err_at = -1;
  logic        clr = 1'b0;
  logic [31:0] exp_seed = 32'h1;
  int          wr_n = 0, wr_bad = 0, rd_n = 0, rd_bad = 0, outst = 0, max_out = 0;

  // RAM slave: responds ack_lat cycles after each accepted request, in order.
  always @(posedge clk) begin
    int    k;
    resp_t r;
    k = now;
    now = now + 1;
    if (rst || clr) begin
      wr_n = 0; wr_bad = 0; rd_n = 0; rd_bad = 0; outst = 0; max_out = 0;
      rq.delete();
    end
    if (rst) begin
      i_wb_ack <= 1'b0; i_wb_err <= 1'b0; i_wb_stall <= 1'b0; i_wb_data <= '0;
    end else begin
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        r.due = k + ack_lat; r.err = 1'b0; r.data = '0;
        if (o_wb_we) begin
          if (int'(o_wb_addr) != wr_n || o_wb_data != lfsr_at(exp_seed, wr_n)) wr_bad++;
          if (err_at == wr_n) r.err = 1'b1;
          mem[o_wb_addr] = o_wb_data;
          wr_n++;
        end else begin
          if (int'(o_wb_addr) != rd_n) rd_bad++;
          r.data = mem[o_wb_addr] ^ ((int'(o_wb_addr) == corrupt_at) ? 32'h1 : 32'h0);
          rd_n++;
        end
        rq.push_back(r);
        outst++;
      end
      if (o_wb_cyc && (i_wb_ack || i_wb_err) && outst > 0) outst--;
      if (outst > max_out) max_out = outst;
      if (rq.size() > 0 && rq[0].due <= now) begin
        r = rq.pop_front();
        i_wb_ack  <= !r.err;
        i_wb_err  <= r.err;
        i_wb_data <= r.data;
      end else begin
        i_wb_ack  <= 1'b0;
        i_wb_err  <= 1'b0;
        i_wb_data <= $urandom;
      end
      i_wb_stall <= (stall_alt != 0) ? !i_wb_stall : 1'b0;
    end
  end

  int            n_cmp = 0, n_bad = 0;
  logic [3:0]    ps_ctl;
  logic [AW-1:0] ps_addr;
  logic [31:0]   ps_data;
  int            wcyc, gapc, done_n;
  logic          busy_at_done, fr_seen, fr_cyc, fr_done;

  task automatic run_pass(input logic [31:0] s, input int lst, input bit poke);
    exp_seed = (s == 32'h0) ? 32'h1 : s;
    @(negedge clk);
    i_seed = s; i_last = AW'(lst); i_start = 1'b1; clr = 1'b1;
    @(negedge clk);
    i_start = 1'b0; clr = 1'b0; i_seed = $urandom; i_last = AW'($urandom);
    ps_ctl = {o_busy, o_wb_cyc, o_wb_stb, o_wb_we};
    ps_addr = o_wb_addr; ps_data = o_wb_data;
    wcyc = 0; gapc = 0; done_n = 0; busy_at_done = 1'b1;
    fr_seen = 1'b0; fr_cyc = 1'b1; fr_done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (o_wb_cyc && o_wb_we) wcyc++;
      if (o_busy && !o_wb_cyc) gapc++;
      if (o_fail && !fr_seen) begin fr_seen = 1'b1; fr_cyc = o_wb_cyc; fr_done = o_done; end
      if (o_done) begin done_n = 1; busy_at_done = o_busy; break; end
      i_start = poke && (i == 3);
      @(negedge clk);
    end
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done) done_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({o_busy, o_done, o_fail} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b want 000", {o_busy, o_done, o_fail}); end
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we}); end
    n_cmp++; if (o_wb_addr !== '0 || o_wb_data !== '0) begin n_bad++; $display("FAIL reset_req: got addr %h data %h want 0 0", o_wb_addr, o_wb_data); end
    n_cmp++; if (o_fail_addr !== '0 || o_fail_data !== '0) begin n_bad++; $display("FAIL reset_failinfo: got %h %h want 0 0", o_fail_addr, o_fail_data); end
    n_cmp++; if (o_wb_sel !== 4'hf) begin n_bad++; $display("FAIL reset_sel: got %h want f", o_wb_sel); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    stall_alt = 0; ack_lat = 1; corrupt_at = -1; err_at = -1;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    run_pass(32'h1, 3, 1'b0);
    n_cmp++; if (ps_ctl !== 4'b1111) begin n_bad++; $display("FAIL basic_first_ctl: got %b want 1111", ps_ctl); end
    n_cmp++; if (ps_addr !== '0 || ps_data !== 32'h1) begin n_bad++; $display("FAIL basic_first_req: got %h %h want 0 1", ps_addr, ps_data); end
    n_cmp++; if (mem[0] !== 32'h1 || mem[1] !== 32'h8020_0003 || mem[2] !== 32'hC030_0002 || mem[3] !== 32'h6018_0001) begin
      n_bad++; $display("FAIL basic_words: got %h %h %h %h want 1 80200003 c0300002 60180001", mem[0], mem[1], mem[2], mem[3]); end
    n_cmp++; if (wr_n !== 4 || rd_n !== 4) begin n_bad++; $display("FAIL basic_counts: got wr %0d rd %0d want 4 4", wr_n, rd_n); end
    n_cmp++; if (done_n !== 1 || busy_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_done: got %0d busy %b want 1 0", done_n, busy_at_done); end
    n_cmp++; if (o_fail !== 1'b0) begin n_bad++; $display("FAIL basic_fail: got %b want 0", o_fail); end
    n_cmp++; if (wcyc !== 5 || gapc !== 1) begin n_bad++; $display("FAIL basic_timing: got wcyc %0d gap %0d want 5 1", wcyc, gapc); end
  endtask

  task automatic test_stall();
    stall_alt = 1; ack_lat = 3; corrupt_at = -1; err_at = -1;
    run_pass($urandom, 9, 1'b0);
    n_cmp++; if (max_out > 3) begin n_bad++; $display("FAIL stall_outstanding: got %0d want <=3", max_out); end
    n_cmp++; if (done_n !== 1 || o_fail !== 1'b0 || wr_bad !== 0 || rd_n !== 10) begin
      n_bad++; $display("FAIL stall_pass: got done %0d fail %b wrbad %0d rd %0d want 1 0 0 10", done_n, o_fail, wr_bad, rd_n); end
    stall_alt = 0; ack_lat = 3;
    run_pass($urandom, 11, 1'b0);
    n_cmp++; if (max_out !== 3) begin n_bad++; $display("FAIL limit_outstanding: got %0d want 3", max_out); end
    n_cmp++; if (done_n !== 1 || o_fail !== 1'b0 || rd_n !== 12) begin n_bad++; $display("FAIL limit_pass: got done %0d fail %b rd %0d want 1 0 12", done_n, o_fail, rd_n); end
  endtask

  task automatic test_corrupt();
    stall_alt = 0; ack_lat = 1; corrupt_at = 2; err_at = -1;
    run_pass(32'h1, 3, 1'b0);
    n_cmp++; if (o_fail !== 1'b1 || o_fail_addr !== AW'(2) || o_fail_data !== 32'hC030_0003) begin
      n_bad++; $display("FAIL corrupt_report: got %b %h %h want 1 02 c0300003", o_fail, o_fail_addr, o_fail_data); end
    n_cmp++; if (fr_cyc !== 1'b0 || fr_done !== 1'b1 || done_n !== 1) begin
      n_bad++; $display("FAIL corrupt_abort: got cyc %b done %b n %0d want 0 1 1", fr_cyc, fr_done, done_n); end
    corrupt_at = -1;
  endtask

  task automatic test_bus_error();
    stall_alt = 0; ack_lat = 1; corrupt_at = -1; err_at = 1;
    run_pass($urandom, 5, 1'b0);
    n_cmp++; if (o_fail !== 1'b1 || o_fail_addr !== AW'(1) || o_fail_data !== 32'h0) begin
      n_bad++; $display("FAIL buserr_report: got %b %h %h want 1 01 0", o_fail, o_fail_addr, o_fail_data); end
    n_cmp++; if (rd_n !== 0 || done_n !== 1 || gapc !== 0) begin
      n_bad++; $display("FAIL buserr_noread: got rd %0d done %0d gap %0d want 0 1 0", rd_n, done_n, gapc); end
    err_at = -1;
  endtask

  task automatic test_seed_zero();
    stall_alt = 0; ack_lat = 1; corrupt_at = -1; err_at = -1;
    mem[0] = 32'h5555_5555;
    run_pass(32'h0, 0, 1'b0);
    n_cmp++; if (wr_n !== 1 || rd_n !== 1 || mem[0] !== 32'h1) begin
      n_bad++; $display("FAIL seed0_single: got wr %0d rd %0d word %h want 1 1 1", wr_n, rd_n, mem[0]); end
    n_cmp++; if (o_fail !== 1'b0 || done_n !== 1) begin n_bad++; $display("FAIL seed0_pass: got fail %b done %0d want 0 1", o_fail, done_n); end
  endtask

  task automatic test_boundary();
    stall_alt = 0; ack_lat = 1; corrupt_at = -1; err_at = -1;
    run_pass($urandom, NW - 1, 1'b0);
    n_cmp++; if (wr_n !== NW || rd_n !== NW || wr_bad !== 0 || rd_bad !== 0) begin
      n_bad++; $display("FAIL top_range: got wr %0d rd %0d bad %0d %0d want %0d %0d 0 0", wr_n, rd_n, wr_bad, rd_bad, NW, NW); end
    n_cmp++; if (o_fail !== 1'b0 || done_n !== 1) begin n_bad++; $display("FAIL top_pass: got fail %b done %0d want 0 1", o_fail, done_n); end
  endtask

  task automatic test_reset_mid_read();
    bit found;
    int dn;
    stall_alt = 0; ack_lat = 1; corrupt_at = -1; err_at = -1;
    @(negedge clk);
    i_seed = $urandom; i_last = AW'(20); i_start = 1'b1; clr = 1'b1;
    @(negedge clk);
    i_start = 1'b0; clr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (o_wb_cyc && !o_wb_we) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midrst_reach_read: got no read phase want read phase"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_busy, o_done} !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_outputs: got %b want 0000", {o_wb_cyc, o_wb_stb, o_busy, o_done}); end
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done || o_wb_cyc) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", dn); end
    run_pass($urandom, 12, 1'b0);
    n_cmp++; if (done_n !== 1 || o_fail !== 1'b0 || wr_bad !== 0 || rd_n !== 13) begin
      n_bad++; $display("FAIL midrst_rerun: got done %0d fail %b wrbad %0d rd %0d want 1 0 0 13", done_n, o_fail, wr_bad, rd_n); end
  endtask

  task automatic test_random();
    logic [31:0] s;
    int          lst;
    for (int it = 0; it < 6; it++) begin
      s = $urandom;
      lst = int'($urandom_range(0, 20));
      stall_alt = int'($urandom_range(0, 1));
      ack_lat = int'($urandom_range(1, 4));
      err_at = -1;
      if ($urandom_range(0, 1) == 1) corrupt_at = int'($urandom_range(0, lst));
      else corrupt_at = -1;
      run_pass(s, lst, it == 2);
      n_cmp++; if (done_n !== 1 || wr_n !== lst + 1 || wr_bad !== 0 || max_out > 3) begin
        n_bad++; $display("FAIL rand%0d_write: got done %0d wr %0d bad %0d out %0d want 1 %0d 0 <=3", it, done_n, wr_n, wr_bad, max_out, lst + 1); end
      if (corrupt_at < 0) begin
        n_cmp++; if (o_fail !== 1'b0 || rd_n !== lst + 1 || rd_bad !== 0) begin
          n_bad++; $display("FAIL rand%0d_pass: got fail %b rd %0d want 0 %0d", it, o_fail, rd_n, lst + 1); end
      end else begin
        n_cmp++; if (o_fail !== 1'b1 || o_fail_addr !== AW'(corrupt_at) || o_fail_data !== (lfsr_at(s, corrupt_at) ^ 32'h1)) begin
          n_bad++; $display("FAIL rand%0d_miscompare: got %b %h %h want 1 %h %h", it, o_fail, o_fail_addr, o_fail_data,
                            AW'(corrupt_at), lfsr_at(s, corrupt_at) ^ 32'h1); end
      end
    end
    corrupt_at = -1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_bus_error();
    test_seed_zero();
    test_boundary();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbmemtest.md
# wbmemtest

Pipelined Wishbone initiator that writes an LFSR pattern across a word range and reads it back for comparison. It drives any pipelined Wishbone memory slave on the bus, such as the 16-bit-SRAM bridge, through a full write/read-verify pass. A single pulse starts the pass, which ends with a pass/fail report. It is the board-level memory self-test and the bench stimulus for the SRAM path.

## Interface
- AW, 15, Wishbone word-address width.
- LGOUT, 2, log2 of the outstanding-request limit; at most 2^LGOUT-1 requests are unacknowledged.
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- i_start  in  1  start pulse; honoured only in IDLE.
- i_seed  in  32  LFSR seed, sampled on start; zero is replaced by 32'h1.
- i_last  in  AW  last word address of the test range; the range is 0..i_last inclusive, sampled on start.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle pulse at the end of the pass.
- o_fail  out  1  sticky failure flag; cleared by the next accepted start.
- o_fail_addr  out  AW  address of the first miscompare or bus error.
- o_fail_data  out  32  data read at the first miscompare; 0 on bus error.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  AW  request address.
- o_wb_data  out  32  write data.
- o_wb_sel  out  4  always 4'hf.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses.
- i_wb_data  in  32  read data.

## Operation
- LFSR step: next = (l>>1) ^ (l[0] ? 32'h8020_0003 : 0). Word k carries the seed stepped k times.
- There are two LFSRs:
  - The issue LFSR advances on each accepted write.
  - The check LFSR advances on each read ack.
- Both are reloaded from the seed at the start of each phase.
- States and transitions:
  - IDLE → WRITE on i_start.
  - WRITE: issue writes 0..last, then wait for all acks → GAP.
  - GAP: one cycle with cyc low → READ.
  - READ: issue reads 0..last and compare each ack in order; when all are acknowledged → DONE.
  - DONE: pulse o_done → IDLE.
- A request is accepted when o_wb_stb && !i_wb_stall. On acceptance, o_wb_addr increments and the issue LFSR steps.
- o_wb_stb is held while the outstanding count is below its limit and requests remain.
- Outstanding counter (LGOUT bits):
  - +1 on accept, -1 on ack.
  - Unchanged when both occur in the same cycle.
  - An ack with count 0 is ignored.
- Miscompare, or i_wb_err in either phase:
  - Set o_fail and capture o_fail_addr/o_fail_data; only the first failure is captured.
  - Drop cyc and stb on the next edge (abort) → DONE.
- i_start while busy is ignored. An ack arriving while cyc is low is ignored.
- Reset values: every output is 0 except o_wb_sel = 4'hf. The state returns to IDLE.
- Reset mid-pass: cyc/stb are low after the reset edge, and no o_done is pulsed.

## Timing
- The cycle after the start edge: o_busy = 1, o_wb_cyc = o_wb_stb = o_wb_we = 1, addr = 0, data = seed.
- With a zero-wait slave (no stall, ack the cycle after accept), the write phase occupies i_last+2 cycles with cyc high.
- Between phases: exactly one cycle with cyc low.
- Compare is registered: o_fail rises one cycle after the offending ack.
- o_done and o_busy fall together in the cycle o_done pulses.
- For i_last = 0, exactly one write and one read are issued.
- The address counter does not wrap: the counter stops at i_last, including i_last = 2^AW-1.

## Structure
- Shared package holds:
  - LFSR tap constant 32'h8020_0003.
  - State encoding: IDLE, WRITE, GAP, READ, DONE.
- One natural sub-module, wbmemtest_lfsr: a 32-bit step with load and enable, instantiated twice (issue and check).

## Test plan
- Zero-wait RAM model, seed 1, last 3:
  - Writes are 1, 8020_0003, C030_0002, 6018_0001 at addresses 0..3.
  - All four read back, o_done pulses, o_fail = 0.
- Slave stalls every other cycle and acks after 3 cycles, LGOUT = 2:
  - Outstanding never exceeds 3.
  - The pass completes with o_fail = 0.
- RAM model corrupts word 2 on read (XOR 1):
  - o_fail = 1, o_fail_addr = 2, o_fail_data = C030_0003.
  - cyc drops, o_done pulses.
- i_wb_err on the second write: o_fail = 1, o_fail_addr = 1, o_fail_data = 0, no read phase.
- Seed 0, last 0: one write of 32'h1; read returns 1; pass.
- i_reset asserted mid-READ: the next cycle has cyc = stb = busy = 0 and no o_done; a new start afterwards runs a clean pass.
